// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle.
// Groups the run control, instruction memory fetch handshake, decode/execute
// handshake, PC redirect and status signals between the sequencer and its
// environment.
//   master : the sequencer (drives o_* signals, samples i_* signals)
//   slave  : the surrounding core / memory / testbench
interface fetch_sequencer_if;
  logic        i_run;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_valid;
  logic        o_state;
  logic        i_fetch_over;
  logic [31:0] i_instruction;
  logic        o_exec_start;
  logic        i_exec_done;
  logic        i_pc_load;
  logic [31:0] i_pc_target;
  logic [31:0] o_pc;
  logic        o_halted;
  logic [1:0]  o_cause;
  logic [31:0] o_retired;

  modport master (
    input  i_run,
    output o_mem_req,
    output o_mem_addr,
    input  i_mem_valid,
    output o_state,
    input  i_fetch_over,
    input  i_instruction,
    output o_exec_start,
    input  i_exec_done,
    input  i_pc_load,
    input  i_pc_target,
    output o_pc,
    output o_halted,
    output o_cause,
    output o_retired
  );

  modport slave (
    output i_run,
    input  o_mem_req,
    input  o_mem_addr,
    output i_mem_valid,
    input  o_state,
    output i_fetch_over,
    output i_instruction,
    input  o_exec_start,
    output i_exec_done,
    output i_pc_load,
    output i_pc_target,
    input  o_pc,
    input  o_halted,
    input  o_cause,
    input  o_retired
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer.
// Steps a program counter through IDLE -> FETCH -> DECODE -> EXECUTE and back,
// with halts on illegal instruction, bus timeout and misaligned next PC.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : fetch_sequencer_if.master (run, fetch handshake, decode/execute
//           handshake, redirect, PC / halt / retired-count status)
// Parameters:
//   RESET_PC : PC loaded on reset
//   TIMEOUT  : FETCH cycles without i_mem_valid before a bus-timeout halt (2..65535)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input logic               clk,
  input logic               rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StHalt
  } state_e;

  localparam logic [15:0] TmoLast     = 16'(TIMEOUT - 1);
  localparam logic [31:0] IllegalCode = 32'd255;

  localparam logic [1:0] CauseIllegal  = 2'd1;
  localparam logic [1:0] CauseTimeout  = 2'd2;
  localparam logic [1:0] CauseMisalign = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [15:0] tmo_q, tmo_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] next_pc;

  logic mem_req_q;
  logic phase_q;
  logic exec_start_q;
  logic halted_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    tmo_d     = tmo_q;
    cause_d   = cause_q;
    // Sequential PC wraps naturally at 2^32.
    next_pc   = bus.i_pc_load ? bus.i_pc_target : pc_q + 32'd4;

    case (state_q)
      StIdle: begin
        if (bus.i_run) state_d = StFetch;
      end
      StFetch: begin
        // Valid beats the timeout when both land on the same cycle.
        if (bus.i_mem_valid) begin
          state_d = StDecode;
          tmo_d   = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = StHalt;
          cause_d = CauseTimeout;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StDecode: begin
        if (bus.i_fetch_over) begin
          if (bus.i_instruction == IllegalCode) begin
            state_d = StHalt;
            cause_d = CauseIllegal;
          end else begin
            state_d = StExecute;
          end
        end
      end
      StExecute: begin
        if (bus.i_exec_done) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          // A misaligned target still retires and is loaded before halting.
          if (next_pc[1:0] != 2'b00) begin
            state_d = StHalt;
            cause_d = CauseMisalign;
          end else if (bus.i_run) begin
            state_d = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      retired_q    <= '0;
      tmo_q        <= '0;
      cause_q      <= '0;
      mem_req_q    <= 1'b0;
      phase_q      <= 1'b1;
      exec_start_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      retired_q    <= retired_d;
      tmo_q        <= tmo_d;
      cause_q      <= cause_d;
      mem_req_q    <= (state_d == StFetch);
      phase_q      <= (state_d != StFetch);
      exec_start_q <= (state_d == StExecute) && (state_q != StExecute);
      halted_q     <= (state_d == StHalt);
    end
  end

  assign bus.o_mem_req    = mem_req_q;
  assign bus.o_mem_addr   = pc_q;
  assign bus.o_state      = phase_q;
  assign bus.o_exec_start = exec_start_q;
  assign bus.o_pc         = pc_q;
  assign bus.o_halted     = halted_q;
  assign bus.o_cause      = cause_q;
  assign bus.o_retired    = retired_q;

endmodule
